uart_rx: RTL and testbench

Serial receiver that sits directly downstream of the UART transmitter on the same 8N1 link. It oversamples the line at 16x the bit rate, validates the start bit, and shifts in 8 data bits LSB first. It then checks the stop bit and presents the byte on a level-valid/acknowledge interface to the consuming logic. Line format matches the transmitter exactly: idle high, one start bit (0), D0..D7, one stop bit (1).

---
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver with a level-valid/acknowledge byte interface.
// Define UART_RX_PARITY_EN for 8E1 framing (adds the PARITY state and the ParityErr pulse).
module uart_rx #(
   parameter int unsigned CLK_DIV = 326
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       RxIn,
   input  logic       RdAck,
   output logic [7:0] DataOut,
   output logic       RxValid,
   output logic       Overrun,
   output logic       FrameErr,
`ifdef UART_RX_PARITY_EN
   output logic       ParityErr,
`endif
   output logic       Busy
);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t      state, state_nxt;
   logic        rx_meta, rxs;
   logic [15:0] div_cnt;
   logic        tick;
   logic [3:0]  tcnt, tcnt_nxt;
   logic [2:0]  bcnt, bcnt_nxt;
   logic [7:0]  shift, shift_nxt;
   logic        done_q, done_nxt;
   logic        stop_q, stop_nxt;
   logic        byte_ok;
`ifdef UART_RX_PARITY_EN
   logic        par_bit, par_bit_nxt;
   logic        par_bad;
`endif

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= RxIn;
         rxs     <= rx_meta;
      end
   end

   // Free-running: phase is independent of line activity.
   assign tick = (div_cnt == 16'(CLK_DIV - 1));

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) div_cnt <= '0;
      else          div_cnt <= tick ? '0 : div_cnt + 16'd1;
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         tcnt    <= '0;
         bcnt    <= '0;
         shift   <= '0;
         done_q  <= 1'b0;
         stop_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         tcnt    <= tcnt_nxt;
         bcnt    <= bcnt_nxt;
         shift   <= shift_nxt;
         done_q  <= done_nxt;
         stop_q  <= stop_nxt;
`ifdef UART_RX_PARITY_EN
         par_bit <= par_bit_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt   = state;
      tcnt_nxt    = tcnt;
      bcnt_nxt    = bcnt;
      shift_nxt   = shift;
      done_nxt    = 1'b0;
      stop_nxt    = stop_q;
`ifdef UART_RX_PARITY_EN
      par_bit_nxt = par_bit;
`endif
      if (tick) begin
         case (state)
            IDLE: begin
               tcnt_nxt = '0;
               if (!rxs) state_nxt = START;
            end
            START: begin
               if (tcnt == 4'd7) begin
                  tcnt_nxt = '0;
                  bcnt_nxt = '0;
                  state_nxt = rxs ? IDLE : DATA;
               end else begin
                  tcnt_nxt = tcnt + 4'd1;
               end
            end
            DATA: begin
               tcnt_nxt = tcnt + 4'd1;
               if (tcnt == 4'd15) begin
                  shift_nxt[bcnt] = rxs;
                  bcnt_nxt = bcnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (bcnt == 3'd7) state_nxt = PARITY;
`else
                  if (bcnt == 3'd7) state_nxt = STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               tcnt_nxt = tcnt + 4'd1;
               if (tcnt == 4'd15) begin
                  par_bit_nxt = rxs;
                  state_nxt = STOP;
               end
            end
`endif
            STOP: begin
               tcnt_nxt = tcnt + 4'd1;
               if (tcnt == 4'd15) begin
                  stop_nxt  = rxs;
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
               tcnt_nxt  = '0;
            end
         endcase
      end
   end

   assign Busy = (state != IDLE);

   // shift and par_bit hold steady until the next frame's D0, so the checks can run a cycle late.
`ifdef UART_RX_PARITY_EN
   assign par_bad = ^{shift, par_bit};
   assign byte_ok = done_q & stop_q & ~par_bad;
`else
   assign byte_ok = done_q & stop_q;
`endif

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         DataOut   <= '0;
         RxValid   <= 1'b0;
         Overrun   <= 1'b0;
         FrameErr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         ParityErr <= 1'b0;
`endif
      end else begin
         FrameErr  <= done_q & ~stop_q;
`ifdef UART_RX_PARITY_EN
         ParityErr <= done_q & par_bad;
`endif
         if (byte_ok) begin
            DataOut <= shift;
            RxValid <= 1'b1;
            if (RxValid && !RdAck) Overrun <= 1'b1;
            else if (RdAck)        Overrun <= 1'b0;
         end else if (RdAck && RxValid) begin
            RxValid <= 1'b0;
            Overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLK_DIV=4 (one bit = 64 clocks).
// Honors UART_RX_PARITY_EN to add the parity directed steps.
module tb_uart_rx;

   localparam int BIT_CYC = 64;

   logic       CLOCK_50;
   logic       reset_n;
   logic       RxIn;
   logic       RdAck;
   logic [7:0] DataOut;
   logic       RxValid;
   logic       Overrun;
   logic       FrameErr;
   logic       Busy;
`ifdef UART_RX_PARITY_EN
   logic       ParityErr;
   logic       par_flip;
   int         pe_cycles = 0;
   int         pe_base;
`endif

   int tests = 0;
   int fails = 0;
   int fe_cycles = 0;
   int busy_cycles = 0;
   int fe_base;
   int busy_base;

   uart_rx #(.CLK_DIV(4)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .RxIn     (RxIn),
      .RdAck    (RdAck),
      .DataOut  (DataOut),
      .RxValid  (RxValid),
      .Overrun  (Overrun),
      .FrameErr (FrameErr),
`ifdef UART_RX_PARITY_EN
      .ParityErr(ParityErr),
`endif
      .Busy     (Busy)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      if (FrameErr) fe_cycles++;
      if (Busy)     busy_cycles++;
`ifdef UART_RX_PARITY_EN
      if (ParityErr) pe_cycles++;
`endif
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic v);
      RxIn = v;
      cyc(BIT_CYC);
   endtask

   // With ack_at_end, RdAck is pulsed in the cycle right after Busy drops (the completion cycle).
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic ack_at_end);
      int  n;
      logic acked;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(^b ^ par_flip);
`endif
      RxIn  = stop_v;
      n     = 0;
      acked = 1'b0;
      while (n < BIT_CYC) begin
         cyc(1);
         n++;
         if (ack_at_end && !acked && !Busy) begin
            RdAck = 1'b1;
            cyc(1);
            n++;
            RdAck = 1'b0;
            acked = 1'b1;
         end
      end
      if (ack_at_end) check("ack_window", int'(acked), 1);
   endtask

   task automatic ack_pulse();
      RdAck = 1'b1;
      cyc(1);
      RdAck = 1'b0;
      cyc(2);
   endtask

   initial begin
      RxIn    = 1'b1;
      RdAck   = 1'b0;
      reset_n = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_flip = 1'b0;
`endif
      cyc(3);
      reset_n = 1'b1;
      cyc(10);
      check("rst_data",  int'(DataOut),  8'h00);
      check("rst_valid", int'(RxValid),  0);
      check("rst_ovr",   int'(Overrun),  0);
      check("rst_fe",    int'(FrameErr), 0);
      check("rst_busy",  int'(Busy),     0);

      // Framing error: 0x3C with a low stop bit.
      fe_base = fe_cycles;
      send_frame(8'h3C, 1'b0, 1'b0);
      RxIn = 1'b1;
      cyc(2 * BIT_CYC);
      check("ferr_pulse", fe_cycles - fe_base, 1);
      check("ferr_valid", int'(RxValid), 0);
      check("ferr_data",  int'(DataOut), 8'h00);
      check("ferr_busy",  int'(Busy),    0);

      // Good byte 0xA5 then acknowledge.
      fe_base = fe_cycles;
      send_frame(8'hA5, 1'b1, 1'b0);
      check("good_data",  int'(DataOut), 8'hA5);
      check("good_valid", int'(RxValid), 1);
      check("good_ovr",   int'(Overrun), 0);
      check("good_busy",  int'(Busy),    0);
      check("good_nofe",  fe_cycles - fe_base, 0);
      ack_pulse();
      check("ack_valid", int'(RxValid), 0);
      check("ack_data",  int'(DataOut), 8'hA5);
      ack_pulse();
      check("ack_idle_valid", int'(RxValid), 0);

      // Glitch: 12 low cycles is rejected at mid start.
      fe_base   = fe_cycles;
      busy_base = busy_cycles;
      RxIn = 1'b0;
      cyc(12);
      RxIn = 1'b1;
      cyc(BIT_CYC);
      check("glitch_busy_seen", int'(busy_cycles > busy_base), 1);
      check("glitch_busy",  int'(Busy),    0);
      check("glitch_valid", int'(RxValid), 0);
      check("glitch_nofe",  fe_cycles - fe_base, 0);

      // Overrun: 0x12 then 0x34 back-to-back, no acknowledge.
      send_frame(8'h12, 1'b1, 1'b0);
      check("ovr1_data",  int'(DataOut), 8'h12);
      check("ovr1_valid", int'(RxValid), 1);
      check("ovr1_ovr",   int'(Overrun), 0);
      send_frame(8'h34, 1'b1, 1'b0);
      check("ovr2_data",  int'(DataOut), 8'h34);
      check("ovr2_valid", int'(RxValid), 1);
      check("ovr2_ovr",   int'(Overrun), 1);
      ack_pulse();
      check("ovr_clr_valid", int'(RxValid), 0);
      check("ovr_clr_ovr",   int'(Overrun), 0);

      // Same pair, acknowledge coincides with 0x34 completion.
      send_frame(8'h12, 1'b1, 1'b0);
      send_frame(8'h34, 1'b1, 1'b1);
      check("sack_data",  int'(DataOut), 8'h34);
      check("sack_valid", int'(RxValid), 1);
      check("sack_ovr",   int'(Overrun), 0);

      // Reset during D3 of 0xFF, then receive 0x81.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      RxIn = 1'b1;
      cyc(32);
      reset_n = 1'b0;
      cyc(2);
      check("mrst_data",  int'(DataOut),  8'h00);
      check("mrst_valid", int'(RxValid),  0);
      check("mrst_ovr",   int'(Overrun),  0);
      check("mrst_fe",    int'(FrameErr), 0);
      check("mrst_busy",  int'(Busy),     0);
      reset_n = 1'b1;
      cyc(8);
      check("mrst_rel_busy",  int'(Busy),    0);
      check("mrst_rel_valid", int'(RxValid), 0);
      fe_base = fe_cycles;
      send_frame(8'h81, 1'b1, 1'b0);
      check("post_data",  int'(DataOut), 8'h81);
      check("post_valid", int'(RxValid), 1);
      check("post_nofe",  fe_cycles - fe_base, 0);

`ifdef UART_RX_PARITY_EN
      ack_pulse();
      check("par_pre_valid", int'(RxValid), 0);
      // 0x07 has three ones: even parity bit is 1, so flipping sends 0.
      pe_base  = pe_cycles;
      fe_base  = fe_cycles;
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1, 1'b0);
      check("par_bad_pulse", pe_cycles - pe_base, 1);
      check("par_bad_valid", int'(RxValid), 0);
      check("par_bad_nofe",  fe_cycles - fe_base, 0);
      pe_base  = pe_cycles;
      par_flip = 1'b0;
      send_frame(8'h07, 1'b1, 1'b0);
      check("par_ok_data",  int'(DataOut), 8'h07);
      check("par_ok_valid", int'(RxValid), 1);
      check("par_ok_nope",  pe_cycles - pe_base, 0);
`endif

      cyc(4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
